// File: rtl/digit_link_rx.sv
// Receives one-digit SPI frames from an MCU and debounces the
// instruction push-button for the digit display.
module digit_link_rx #(
  parameter logic [18:0] DEB_CYCLES     = 19'd400000,
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd40000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs_n,
  input  logic       btn,
  output logic [3:0] digit,
  output logic       digitEn,
  output logic       instrEn,
  output logic       frameErr
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  state_t      r_state;
  logic        r_sck_s1, r_sck_s2, r_sck_s3;
  logic        r_cs_s1, r_cs_s2, r_cs_s3;
  logic        r_sdi_s1, r_sdi_s2;
  logic        r_btn_s1, r_btn_s2;
  logic [3:0]  r_cnt;
  logic [7:0]  r_shift;
  logic [3:0]  r_digit;
  logic        r_den;
  logic        r_ferr;
  logic [25:0] r_tcnt;
  logic [18:0] r_dcnt;
  logic        r_instr;

  logic w_sck_rise, w_cs_fall, w_cs_rise;
  logic w_ok, w_tout;

  assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
  assign w_cs_fall  = ~r_cs_s2 & r_cs_s3;
  assign w_cs_rise  = r_cs_s2 & ~r_cs_s3;

  assign w_ok = (r_cnt == 4'd8)
             && (r_shift[6:4] == 3'b000)
             && (r_shift[3:0] <= 4'd9);

  assign w_tout = r_den
               && (r_tcnt == TIMEOUT_CYCLES - 26'd1);

  assign digit    = r_digit;
  assign digitEn  = r_den;
  assign instrEn  = r_instr;
  assign frameErr = r_ferr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_s3 <= 1'b0;
      r_cs_s1  <= 1'b1;
      r_cs_s2  <= 1'b1;
      r_cs_s3  <= 1'b1;
      r_sdi_s1 <= 1'b0;
      r_sdi_s2 <= 1'b0;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_sck_s1 <= sck;
      r_sck_s2 <= r_sck_s1;
      r_sck_s3 <= r_sck_s2;
      r_cs_s1  <= cs_n;
      r_cs_s2  <= r_cs_s1;
      r_cs_s3  <= r_cs_s2;
      r_sdi_s1 <= sdi;
      r_sdi_s2 <= r_sdi_s1;
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Acceptance in CHECK is assigned last so it overrides a timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_shift <= 8'd0;
      r_digit <= 4'd0;
      r_den   <= 1'b0;
      r_ferr  <= 1'b0;
      r_tcnt  <= 26'd0;
    end else begin
      r_ferr <= 1'b0;
      if (!r_den) begin
        r_tcnt <= 26'd0;
      end else if (w_tout) begin
        r_den  <= 1'b0;
        r_tcnt <= 26'd0;
      end else begin
        r_tcnt <= r_tcnt + 26'd1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state <= SHIFT;
            r_cnt   <= 4'd0;
            r_shift <= 8'd0;
          end
        end
        SHIFT: begin
          if (w_cs_rise) begin
            r_state <= CHECK;
            r_ferr  <= ~w_ok;
          end else if (w_sck_rise) begin
            r_shift <= {r_shift[6:0], r_sdi_s2};
            if (r_cnt != 4'd9) r_cnt <= r_cnt + 4'd1;
          end
        end
        CHECK: begin
          r_state <= IDLE;
          if (w_ok) begin
            r_digit <= r_shift[3:0];
            r_den   <= r_shift[7];
            r_tcnt  <= 26'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dcnt  <= 19'd0;
      r_instr <= 1'b0;
    end else if (r_btn_s2 == r_instr) begin
      r_dcnt <= 19'd0;
    end else if (r_dcnt == DEB_CYCLES - 19'd1) begin
      r_instr <= r_btn_s2;
      r_dcnt  <= 19'd0;
    end else begin
      r_dcnt <= r_dcnt + 19'd1;
    end
  end

endmodule

// File: doc/digit_link_rx.md
DIGIT_LINK_RX -- requirements
Module: digit_link_rx

Interface
REQ-001 Parameter DEB_CYCLES, default 19'd400000: button stable-time before instrEn changes (10 ms at 40 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 26'd40000000: clk cycles without an accepted frame before digitEn drops (1 s).
REQ-003 clk  input  1  system clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sck  input  1  SPI clock from MCU, asynchronous to clk, mode 0.
REQ-006 sdi  input  1  SPI data from MCU, MSB first, sampled on sck rising edge.
REQ-007 cs_n  input  1  SPI chip select, active-low, frames one transfer.
REQ-008 btn  input  1  raw instruction push-button, active-high, bouncing, asynchronous.
REQ-009 digit  output  4  last accepted digit, 0-9, for the digit display.
REQ-010 digitEn  output  1  high while a valid digit is held and not timed out.
REQ-011 instrEn  output  1  debounced button level; high shows the instruction text.
REQ-012 frameErr  output  1  one-cycle pulse per rejected frame.

Function
REQ-013 sck, sdi, cs_n and btn SHALL each pass through a 2-flop synchronizer; a third flop on sck and cs_n SHALL provide edge detection.
REQ-014 FSM states SHALL be IDLE, SHIFT and CHECK.
REQ-015 IDLE -> SHIFT on synchronized cs_n falling edge; bit counter (4 bits) and shift register (8 bits) SHALL clear on entry.
REQ-016 In SHIFT, each synchronized sck rising edge SHALL shift sdi into bit 0 and increment the counter, saturating at 9.
REQ-017 SHIFT -> CHECK on synchronized cs_n rising edge; sck edges outside SHIFT SHALL be ignored.
REQ-018 CHECK SHALL last exactly one cycle, then return to IDLE.
REQ-019 Frame format: bit 7 = valid flag, bits 6:4 = reserved (must be 0), bits 3:0 = digit.
REQ-020 Frame accepted iff count == 8, bits 6:4 == 0 and bits 3:0 <= 9.
REQ-021 On acceptance, in the CHECK cycle: digit <= bits 3:0, digitEn <= bit 7, and the timeout counter clears; outputs update on the clock edge ending CHECK.
REQ-022 On rejection (count != 8 or a format violation), frameErr SHALL be high for the CHECK cycle only; digit, digitEn and the timeout counter hold.
REQ-023 Timeout counter SHALL increment every cycle while digitEn is high; on reaching TIMEOUT_CYCLES-1 it SHALL clear digitEn and itself; digit holds.
REQ-024 Acceptance and timeout expiry in the same cycle: acceptance wins.
REQ-025 Timeout counter SHALL stay at 0 while digitEn is low.
REQ-026 Debounce: the counter clears whenever synchronized btn equals instrEn; otherwise it increments; on reaching DEB_CYCLES-1, instrEn <= synchronized btn and the counter clears.
REQ-027 Debounce and SPI paths SHALL be independent; instrEn SHALL NOT gate frame reception (the display masks the digit itself).
REQ-028 Input-to-output latency SHALL be fixed: cs_n rising at pin -> digit/digitEn update 4 clk cycles later (2 sync + 1 edge + 1 CHECK).

Reset
REQ-029 Reset SHALL drive the FSM to IDLE and set digit = 4'd0, digitEn = 0, instrEn = 0, frameErr = 0, all counters and shift register = 0, and synchronizer flops cs_n = 1 and sck/sdi/btn = 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no frameErr; the first frame after release SHALL be received only after a fresh cs_n falling edge.

Verification (DEB_CYCLES=8, TIMEOUT_CYCLES=64, sck period >= 8 clk)
REQ-031 Frame 0x87 -> digit=7, digitEn=1 exactly 4 clk after cs_n rises; frameErr stays 0.
REQ-032 Frame 0x0C (digit 12), then frame 0x93 (reserved bit set) -> a frameErr pulse each; digit/digitEn unchanged from the prior value.
REQ-033 Only 7 sck edges, then cs_n high -> frameErr pulse; 9 edges -> frameErr pulse; outputs hold.
REQ-034 Accept 0x85, then idle 64 cycles -> digitEn=0 on cycle 64, digit stays 5; frame 0x05 -> digit=5, digitEn=0, no timeout activity.
REQ-035 btn glitches high for 5 cycles -> instrEn stays 0; btn held high -> instrEn=1 10 cycles after the btn edge (2 sync + 8).
REQ-036 Reset pulsed after 4 bits of 0x89 -> all outputs 0, no frameErr; next full frame 0x89 -> digit=9, digitEn=1.
